multicycle_control_unit: RTL and testbench

- Multicycle MIPS control FSM that replaces the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one memory port.
- Supports a variable-latency memory (ready handshake) and a parametrised multi-cycle multiplier.
- Covers the existing ISA (add, sub, and, or, slt, mul, jr, addi, beq, lw, sw, j, jal) and flags illegal encodings instead of driving X.

---
 rtl/multicycle_control_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// sharing one ALU and one memory port. Memory accesses wait on MemReady,
// MUL occupies MUL_CYCLES execute cycles, and illegal encodings park the
// FSM in a sticky ERROR state until reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 into PC when memory is ready
// DECODE  | branch target PC+(imm<<2) computed into ALUOut
// RTYPE   | A op B for register-register instructions
// MULWAIT | extra multiply cycles, ALU controls held
// ALUWB   | ALUOut -> rd
// MEMADR  | A + imm effective address for lw/sw
// MEMRD   | data read at ALUOut, waits for MemReady
// MEMWB   | MDR -> rt
// MEMWR   | B written at ALUOut, waits for MemReady
// ADDIEX  | A + imm
// ADDIWB  | ALUOut -> rt
// BEQ     | A - B, PC <- ALUOut when Zero
// JUMP    | PC <- jump target
// JALS    | PC <- jump target, r31 <- PC (already PC+4)
// JR      | PC <- rs
// ERROR   | illegal encoding, sticky until reset

module multicycle_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic [1:0]           PCSrc,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic                 JAL,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalOp,
  output logic                 InstrDone
);

  typedef enum logic [3:0] {
    FETCH, DECODE, RTYPE, MULWAIT, ALUWB, MEMADR, MEMRD, MEMWB,
    MEMWR, ADDIEX, ADDIWB, BEQ, JUMP, JALS, JR, ERROR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_MUL = ALUCTRL_W'(3'b011);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

  // RTYPE itself is the first multiply cycle, so MULWAIT covers the rest.
  // Out-of-range parameters are clamped so the 4-bit counter cannot wrap.
  localparam int          MUL_EXTRA = (MUL_CYCLES < 1)  ? 0  :
                                      (MUL_CYCLES > 15) ? 14 : MUL_CYCLES - 1;
  localparam logic [3:0]  MUL_LOAD  = 4'(MUL_EXTRA);
  localparam bit          MUL_SKIP  = (MUL_EXTRA == 0);

  state_t                 state, next_state;
  logic   [3:0]           mul_cnt;
  logic                   funct_legal;
  logic [ALUCTRL_W-1:0]   funct_alu;

  // Funct decode: legality and the ALU operation it selects.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (Funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_MUL:  funct_alu = ALU_MUL;
      FN_JR:   funct_alu = ALU_ADD;
      default: funct_legal = 1'b0;
    endcase
  end

  // State register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= next_state;
  end

  // Multiply down-counter: loaded on entry to MULWAIT, zero everywhere else.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mul_cnt <= 4'd0;
    end else if (state == RTYPE && next_state == MULWAIT) begin
      mul_cnt <= MUL_LOAD;
    end else if (state == MULWAIT && mul_cnt != 4'd0) begin
      mul_cnt <= mul_cnt - 4'd1;
    end else begin
      mul_cnt <= 4'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (MemReady) next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_RTYPE: begin
            if (!funct_legal)        next_state = ERROR;
            else if (Funct == FN_JR) next_state = JR;
            else                     next_state = RTYPE;
          end
          OP_LW, OP_SW: next_state = MEMADR;
          OP_ADDI:      next_state = ADDIEX;
          OP_BEQ:       next_state = BEQ;
          OP_J:         next_state = JUMP;
          OP_JAL:       next_state = JALS;
          default:      next_state = ERROR;
        endcase
      end
      RTYPE: begin
        if (Funct == FN_MUL && !MUL_SKIP) next_state = MULWAIT;
        else                              next_state = ALUWB;
      end
      // Leave in the cycle the count reaches zero; a zero count also
      // exits so a stray entry can never stall here.
      MULWAIT: if (mul_cnt <= 4'd1) next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      MEMADR:  next_state = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (MemReady) next_state = MEMWB;
      MEMWB:   next_state = FETCH;
      MEMWR:   if (MemReady) next_state = FETCH;
      ADDIEX:  next_state = ADDIWB;
      ADDIWB:  next_state = FETCH;
      BEQ:     next_state = FETCH;
      JUMP:    next_state = FETCH;
      JALS:    next_state = FETCH;
      JR:      next_state = FETCH;
      ERROR:   next_state = ERROR;
      default: next_state = ERROR;
    endcase
  end

  // Moore output decode; everything forced low while reset is held.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 2'b00;
    RegWrite   = 1'b0;
    JAL        = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    IllegalOp  = 1'b0;
    InstrDone  = 1'b0;
    if (!RST) begin
      case (state)
        FETCH: begin
          MemRead    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          PCWrite    = MemReady;
          IRWrite    = MemReady;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
        end
        RTYPE, MULWAIT: begin
          ALUSrcA    = 1'b1;
          ALUControl = funct_alu;
        end
        ALUWB: begin
          RegDst    = 2'b01;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        MEMADR, ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
        end
        MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        MEMWB: begin
          MemtoReg  = 1'b1;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        MEMWR: begin
          IorD      = 1'b1;
          MemWrite  = 1'b1;
          InstrDone = MemReady;
        end
        ADDIWB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        BEQ: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          Branch     = 1'b1;
          PCSrc      = 2'b01;
          InstrDone  = 1'b1;
        end
        JUMP: begin
          PCWrite   = 1'b1;
          PCSrc     = 2'b10;
          InstrDone = 1'b1;
        end
        JALS: begin
          PCWrite   = 1'b1;
          PCSrc     = 2'b10;
          RegDst    = 2'b10;
          RegWrite  = 1'b1;
          JAL       = 1'b1;
          InstrDone = 1'b1;
        end
        JR: begin
          PCWrite   = 1'b1;
          PCSrc     = 2'b11;
          InstrDone = 1'b1;
        end
        ERROR:   IllegalOp = 1'b1;
        default: IllegalOp = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected output vectors are
// queued as stimulus is planned, then compared as the DUT steps through them.
module tb_multicycle_control_unit;

  localparam int MULC = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegWrite, JAL, ALUSrcA, IllegalOp, InstrDone;
  logic [1:0] PCSrc, RegDst, ALUSrcB;
  logic [2:0] ALUControl;

  multicycle_control_unit #(.MUL_CYCLES(MULC), .ALUCTRL_W(3)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .JAL(JAL),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .IllegalOp(IllegalOp), .InstrDone(InstrDone)
  );

  always #5 CLK = ~CLK;

  logic [21:0] outs;
  assign outs = {PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, JAL, ALUSrcA, ALUSrcB,
                 ALUControl, IllegalOp, InstrDone};

  // bench-side state labels
  localparam int S_F = 0, S_D = 1, S_R = 2, S_MW = 3, S_AWB = 4, S_MA = 5,
                 S_MR = 6, S_MWB = 7, S_MWR = 8, S_AE = 9, S_AIWB = 10,
                 S_BEQ = 11, S_J = 12, S_JAL = 13, S_JR = 14, S_ERR = 15;

  typedef struct {
    int          st;
    logic        rdy;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [21:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string st_name(input int st);
    case (st)
      S_F: return "fetch";    S_D: return "decode";  S_R: return "rtype";
      S_MW: return "mulwait"; S_AWB: return "aluwb"; S_MA: return "memadr";
      S_MR: return "memrd";   S_MWB: return "memwb"; S_MWR: return "memwr";
      S_AE: return "addiex";  S_AIWB: return "addiwb"; S_BEQ: return "beq";
      S_J: return "jump";     S_JAL: return "jal";   S_JR: return "jr";
      default: return "error";
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b011000: return 3'b011;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle, written from the state/output table.
  function automatic logic [21:0] exp_out(input int st, input logic rdy, input logic [5:0] fn);
    logic pcw, br, iord, mrd, mwr, irw, m2r, rw, jl, srca, ill, done;
    logic [1:0] pcs, rdst, srcb;
    logic [2:0] alu;
    {pcw, br, iord, mrd, mwr, irw, m2r, rw, jl, srca, ill, done} = '0;
    pcs = 2'b00; rdst = 2'b00; srcb = 2'b00; alu = 3'b000;
    case (st)
      S_F:    begin mrd = 1; srcb = 2'b01; alu = 3'b010; pcw = rdy; irw = rdy; end
      S_D:    begin srcb = 2'b11; alu = 3'b010; end
      S_R, S_MW: begin srca = 1; alu = alu_of(fn); end
      S_AWB:  begin rdst = 2'b01; rw = 1; done = 1; end
      S_MA, S_AE: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      S_MR:   begin iord = 1; mrd = 1; end
      S_MWB:  begin m2r = 1; rw = 1; done = 1; end
      S_MWR:  begin iord = 1; mwr = 1; done = rdy; end
      S_AIWB: begin rw = 1; done = 1; end
      S_BEQ:  begin srca = 1; alu = 3'b110; br = 1; pcs = 2'b01; done = 1; end
      S_J:    begin pcw = 1; pcs = 2'b10; done = 1; end
      S_JAL:  begin pcw = 1; pcs = 2'b10; rdst = 2'b10; rw = 1; jl = 1; done = 1; end
      S_JR:   begin pcw = 1; pcs = 2'b11; done = 1; end
      default: ill = 1;
    endcase
    return {pcw, br, pcs, iord, mrd, mwr, irw, m2r, rdst, rw, jl, srca, srcb,
            alu, ill, done};
  endfunction

  task automatic push(input int st, input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    sb_t e;
    e.st = st; e.rdy = rdy; e.op = op; e.fn = fn;
    e.exp = exp_out(st, rdy, fn);
    sb.push_back(e);
  endtask

  // Plans the full cycle sequence of one instruction.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fwait, input int mwait);
    logic legal_fn;
    legal_fn = (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b011000, 6'b001000});
    for (int i = 0; i < fwait; i++) push(S_F, 1'b0, op, fn);
    push(S_F, 1'b1, op, fn);
    push(S_D, 1'($urandom_range(1)), op, fn);
    case (op)
      6'b000000: begin
        if (!legal_fn) begin
          for (int i = 0; i < 3; i++) push(S_ERR, 1'($urandom_range(1)), op, fn);
        end else if (fn == 6'b001000) begin
          push(S_JR, 1'($urandom_range(1)), op, fn);
        end else begin
          push(S_R, 1'($urandom_range(1)), op, fn);
          if (fn == 6'b011000)
            for (int i = 0; i < MULC - 1; i++) push(S_MW, 1'($urandom_range(1)), op, fn);
          push(S_AWB, 1'($urandom_range(1)), op, fn);
        end
      end
      6'b100011: begin
        push(S_MA, 1'($urandom_range(1)), op, fn);
        for (int i = 0; i < mwait; i++) push(S_MR, 1'b0, op, fn);
        push(S_MR, 1'b1, op, fn);
        push(S_MWB, 1'($urandom_range(1)), op, fn);
      end
      6'b101011: begin
        push(S_MA, 1'($urandom_range(1)), op, fn);
        for (int i = 0; i < mwait; i++) push(S_MWR, 1'b0, op, fn);
        push(S_MWR, 1'b1, op, fn);
      end
      6'b001000: begin
        push(S_AE, 1'($urandom_range(1)), op, fn);
        push(S_AIWB, 1'($urandom_range(1)), op, fn);
      end
      6'b000100: push(S_BEQ, 1'($urandom_range(1)), op, fn);
      6'b000010: push(S_J, 1'($urandom_range(1)), op, fn);
      6'b000011: push(S_JAL, 1'($urandom_range(1)), op, fn);
      default: for (int i = 0; i < 3; i++) push(S_ERR, 1'($urandom_range(1)), op, fn);
    endcase
  endtask

  // Called at a falling edge: drive, let outputs settle, compare, advance.
  task automatic run_sb();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      MemReady = e.rdy; Op = e.op; Funct = e.fn;
      #1;
      cyc++;
      check_eq($sformatf("%s@%0d", st_name(e.st), cyc), 32'(outs), 32'(e.exp));
      @(negedge CLK);
    end
  endtask

  task automatic reset_pulse();
    #2 RST = 1'b1;
    #1 check_eq("rst_async_outs", 32'(outs), 32'd0);
    @(posedge CLK); #1;
    check_eq("rst_held_outs", 32'(outs), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 check_eq("rst_outs", 32'(outs), 32'd0);
    @(posedge CLK); #1;
    check_eq("rst_clk_outs", 32'(outs), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    plan_instr(6'b000000, 6'b100000, 0, 0);   // add
    plan_instr(6'b000000, 6'b011000, 0, 0);   // mul
    plan_instr(6'b100011, 6'b000000, 2, 3);   // lw with waits
    plan_instr(6'b101011, 6'b000000, 0, 2);   // sw with waits
    plan_instr(6'b000010, 6'b000000, 0, 0);   // j
    plan_instr(6'b000011, 6'b000000, 0, 0);   // jal
    plan_instr(6'b000000, 6'b001000, 0, 0);   // jr
    plan_instr(6'b000100, 6'b000000, 0, 0);   // beq
    plan_instr(6'b000000, 6'b100010, 1, 0);   // sub
    plan_instr(6'b000000, 6'b100100, 0, 0);   // and
    plan_instr(6'b000000, 6'b100101, 0, 0);   // or
    plan_instr(6'b000000, 6'b101010, 0, 0);   // slt
    plan_instr(6'b001000, 6'b000000, 0, 0);   // addi
    plan_instr(6'b100011, 6'b000000, 0, 0);   // lw, no waits
    plan_instr(6'b000000, 6'b111111, 0, 0);   // illegal funct
    run_sb();
    reset_pulse();

    // illegal opcode, then legal opcodes presented while stuck in ERROR
    plan_instr(6'b111111, 6'b000000, 0, 0);
    push(S_ERR, 1'b1, 6'b000000, 6'b100000);
    push(S_ERR, 1'b1, 6'b000010, 6'b000000);
    run_sb();

    // reset abort in the middle of a multiply
    reset_pulse();
    push(S_F, 1'b1, 6'b000000, 6'b011000);
    push(S_D, 1'b1, 6'b000000, 6'b011000);
    push(S_R, 1'b1, 6'b000000, 6'b011000);
    push(S_MW, 1'b1, 6'b000000, 6'b011000);
    run_sb();
    reset_pulse();

    // clean restart: full multiply then add
    plan_instr(6'b000000, 6'b011000, 0, 0);
    plan_instr(6'b000000, 6'b100000, 0, 0);
    run_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
